// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
//   XLEN / CNT_W : datapath and iteration-counter widths
//   op_e         : operation encoding seen on op_in
//   state_e      : sequencer FSM states
package muldiv_seq_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        OpMul   = 2'b00,
        OpMulhu = 2'b01,
        OpDivu  = 2'b10,
        OpRemu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    // DIVU and REMU share the restoring-division datapath.
    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_seq_adder.sv
// 32-bit Sklansky parallel-prefix adder.
//   i_a, i_b  : addends
//   i_car_in  : carry into bit 0
//   o_sum     : i_a + i_b + i_car_in, low 32 bits
//   o_car_out : carry out of bit 31
module muldiv_seq_adder
    import muldiv_seq_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_car_in,
    output logic [XLEN-1:0] o_sum,
    output logic            o_car_out
);

    localparam int unsigned Levels = $clog2(XLEN);

    logic [XLEN-1:0] w_p0;
    logic [XLEN-1:0] w_g;
    logic [XLEN-1:0] w_p;
    logic [XLEN-1:0] w_gn;
    logic [XLEN-1:0] w_pn;

    // Carry-in is folded into bit 0's generate, so after the prefix tree
    // w_g[i] is the carry out of bit i.
    always_comb begin
        w_p0    = i_a ^ i_b;
        w_g     = i_a & i_b;
        w_g[0]  = w_g[0] | (w_p0[0] & i_car_in);
        w_p     = w_p0;
        w_gn    = w_g;
        w_pn    = w_p;
        for (int l = 0; l < int'(Levels); l++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = 0; i < int'(XLEN); i++) begin
                // Bits with bit l set merge with the top node of the
                // preceding 2^l-wide block (Sklansky fan-out).
                if (((i >> l) & 1) == 1) begin
                    w_gn[i] = w_g[i] | (w_p[i] & w_g[((i >> (l + 1)) << (l + 1)) + (1 << l) - 1]);
                    w_pn[i] = w_p[i] & w_p[((i >> (l + 1)) << (l + 1)) + (1 << l) - 1];
                end
            end
            w_g = w_gn;
            w_p = w_pn;
        end
    end

    assign o_sum     = w_p0 ^ {w_g[XLEN-2:0], i_car_in};
    assign o_car_out = w_g[XLEN-1];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer (MUL, MULHU, DIVU, REMU).
// One pass through a shared 32-bit adder per cycle, 32 iterations per op.
//   clk_in   : clock, rising edge
//   rst_in   : asynchronous active-high reset
//   start_in : request, accepted only while busy=0
//   op_in    : 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a_in     : multiplicand / dividend
//   b_in     : multiplier / divisor
//   busy     : high while an op is running or completing
//   done     : one-cycle pulse, result valid from this cycle
//   result   : registered, held until the next completion
// Build option: MULDIV_DIV0_FAST_EN completes DIVU/REMU by zero one edge
// after acceptance instead of running all 32 iterations.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned XLEN_P  = XLEN,
    parameter int unsigned CNT_W_P = CNT_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [1:0]        op_in,
    input  logic [XLEN_P-1:0] a_in,
    input  logic [XLEN_P-1:0] b_in,
    output logic              busy,
    output logic              done,
    output logic [XLEN_P-1:0] result
);

    state_e             r_state;
    op_e                r_op;
    logic [XLEN_P-1:0]  r_acc;
    logic [XLEN_P-1:0]  r_q;
    logic [XLEN_P-1:0]  r_m;
    logic [CNT_W_P-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [XLEN_P-1:0]  r_result;

    logic               w_div;
    logic [XLEN_P-1:0]  w_rem_shift;
    logic [XLEN_P-1:0]  w_add_a;
    logic [XLEN_P-1:0]  w_add_b;
    logic [XLEN_P-1:0]  w_sum;
    logic               w_cout;
    logic               w_take;
    logic [XLEN_P-1:0]  w_acc_nxt;
    logic [XLEN_P-1:0]  w_q_nxt;
    logic [XLEN_P-1:0]  w_final;

    assign w_div       = is_div_op(r_op);
    // Partial remainder shifted left by one, bringing in the next dividend bit.
    assign w_rem_shift = {r_acc[XLEN_P-2:0], r_q[XLEN_P-1]};

    // Divide computes r - m as r + ~m + 1.
    assign w_add_a = w_div ? w_rem_shift : r_acc;
    assign w_add_b = w_div ? ~r_m : r_m;

    muldiv_seq_adder u_adder (
        .i_a       (w_add_a),
        .i_b       (w_add_b),
        .i_car_in  (w_div),
        .o_sum     (w_sum),
        .o_car_out (w_cout)
    );

    // acc[31] set means the shifted remainder is >= 2^32 and so exceeds m.
    assign w_take = r_acc[XLEN_P-1] | w_cout;

    always_comb begin
        w_acc_nxt = r_acc;
        w_q_nxt   = r_q;
        if (w_div) begin
            if (w_take) begin
                w_acc_nxt = w_sum;
                w_q_nxt   = {r_q[XLEN_P-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_rem_shift;
                w_q_nxt   = {r_q[XLEN_P-2:0], 1'b0};
            end
        end else begin
            // {acc,q} shifts right; low product bits drain out through q.
            if (r_q[0]) begin
                w_acc_nxt = {w_cout, w_sum[XLEN_P-1:1]};
                w_q_nxt   = {w_sum[0], r_q[XLEN_P-1:1]};
            end else begin
                w_acc_nxt = {1'b0, r_acc[XLEN_P-1:1]};
                w_q_nxt   = {r_acc[0], r_q[XLEN_P-1:1]};
            end
        end
    end

    always_comb begin
        w_final = w_q_nxt;
        unique case (r_op)
            OpMul:   w_final = w_q_nxt;
            OpMulhu: w_final = w_acc_nxt;
            OpDivu:  w_final = w_q_nxt;
            OpRemu:  w_final = w_acc_nxt;
            default: w_final = w_q_nxt;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= StIdle;
            r_op     <= OpMul;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start_in) begin
                        r_op   <= op_e'(op_in);
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                        if (is_div_op(op_in)) begin
                            r_q <= a_in;
                            r_m <= b_in;
                        end else begin
                            r_q <= b_in;
                            r_m <= a_in;
                        end
`ifdef MULDIV_DIV0_FAST_EN
                        if (is_div_op(op_in) && (b_in == '0)) begin
                            r_state  <= StDone;
                            r_done   <= 1'b1;
                            r_result <= (op_in == OpDivu) ? '1 : a_in;
                        end else begin
                            r_state <= StRun;
                        end
`else
                        r_state <= StRun;
`endif
                    end
                end
                StRun: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + CNT_W_P'(1);
                    if (r_cnt == CNT_W_P'(XLEN_P - 1)) begin
                        r_state  <= StDone;
                        r_done   <= 1'b1;
                        r_result <= w_final;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
